// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline stage fields in, stall/flush/forward
// controls and performance counters out.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;
    logic              redirect;
    logic              wb_valid;
    logic              wb_halt;

    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exdm_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              halted;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  retired_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output redirect, wb_valid, wb_halt,
        input  pc_write, ifid_write, ifid_flush,
        input  idex_bubble, exdm_flush,
        input  fwd_a, fwd_b, halted,
        input  cycle_cnt, bubble_cnt, retired_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  redirect, wb_valid, wb_halt,
        output pc_write, ifid_write, ifid_flush,
        output idex_bubble, exdm_flush,
        output fwd_a, fwd_b, halted,
        output cycle_cnt, bubble_cnt, retired_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Five-stage pipeline hazard controller: RAW stalls, EX forwarding,
// redirect flushes, halt, and CPI counters.
module hazard_ctrl_unit #(
    parameter int REG_AW       = 5,
    parameter int FORWARDING   = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_unit_if.slave bus
);

    localparam int FLW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FLW-1:0] FL_LOAD = FLW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [FLW-1:0]   flush_left_q, flush_left_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       pc_write, ifid_write, ifid_flush;
    logic       idex_bubble, exdm_flush, halted;
    logic [1:0] fwd_a, fwd_b;

    logic rs_v, rt_v;
    logic ld_hit, ex_hit, mem_hit, data_stall;

    // A valid source of r0 can never match, so rd==0 never hazards.
    function automatic logic id_reads(input logic [REG_AW-1:0] rd);
        return (rs_v && (bus.id_rs == rd)) || (rt_v && (bus.id_rt == rd));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (bus.mem_regwrite && (bus.mem_rd == src)) begin
                sel = 2'b10;
            end else if (bus.wb_regwrite && (bus.wb_rd == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        rs_v       = bus.id_use_rs && (bus.id_rs != '0);
        rt_v       = bus.id_use_rt && (bus.id_rt != '0);
        ld_hit     = bus.ex_memread && id_reads(bus.ex_rd);
        ex_hit     = bus.ex_regwrite && id_reads(bus.ex_rd);
        mem_hit    = bus.mem_regwrite && id_reads(bus.mem_rd);
        data_stall = (FORWARDING != 0) ? ld_hit : (ex_hit || mem_hit);
    end

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exdm_flush   = 1'b0;
        halted       = 1'b0;

        unique case (state_q)
            RUN: begin
                if (bus.redirect) begin
                    ifid_flush   = 1'b1;
                    idex_bubble  = 1'b1;
                    exdm_flush   = 1'b1;
                    flush_left_d = FL_LOAD;
                    state_d      = (FL_LOAD != '0) ? FLUSH : RUN;
                end else if (data_stall) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            FLUSH: begin
                ifid_flush = 1'b1;
                if (bus.redirect) begin
                    idex_bubble  = 1'b1;
                    exdm_flush   = 1'b1;
                    flush_left_d = FL_LOAD;
                    state_d      = (FL_LOAD != '0) ? FLUSH : RUN;
                end else if (flush_left_q <= FLW'(1)) begin
                    flush_left_d = '0;
                    state_d      = RUN;
                end else begin
                    flush_left_d = flush_left_q - FLW'(1);
                end
            end
            HALT: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d      = RUN;
                flush_left_d = '0;
            end
        endcase

        if (bus.wb_halt) begin
            state_d = HALT;
        end

        // Reset holds the pipeline frozen and drained, independent of clk.
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exdm_flush  = 1'b1;
            halted      = 1'b0;
        end

        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if ((FORWARDING != 0) && !rst) begin
            fwd_a = fwd_sel(bus.ex_rs);
            fwd_b = fwd_sel(bus.ex_rt);
        end

        cycle_d   = sat_inc(cycle_q, state_q != HALT);
        bubble_d  = sat_inc(bubble_q, (state_q != HALT) &&
                            (idex_bubble || ifid_flush));
        retired_d = sat_inc(retired_q, (state_q != HALT) && bus.wb_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            flush_left_q <= '0;
            cycle_q      <= '0;
            bubble_q     <= '0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            cycle_q      <= cycle_d;
            bubble_q     <= bubble_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exdm_flush  = exdm_flush;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;
    assign bus.halted      = halted;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.bubble_cnt  = bubble_q;
    assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding, stall-only and
// 4-bit-counter instances driven from one shared stimulus set.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic id_use_rs, id_use_rt, ex_regwrite, ex_memread;
    logic mem_regwrite, wb_regwrite, redirect, wb_valid, wb_halt;

    int n_chk  = 0;
    int n_pass = 0;

    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(32)) fi ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(32)) ni ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  si ();

    assign fi.id_rs = id_rs;         assign ni.id_rs = id_rs;
    assign fi.id_rt = id_rt;         assign ni.id_rt = id_rt;
    assign fi.id_use_rs = id_use_rs; assign ni.id_use_rs = id_use_rs;
    assign fi.id_use_rt = id_use_rt; assign ni.id_use_rt = id_use_rt;
    assign fi.ex_rs = ex_rs;         assign ni.ex_rs = ex_rs;
    assign fi.ex_rt = ex_rt;         assign ni.ex_rt = ex_rt;
    assign fi.ex_rd = ex_rd;         assign ni.ex_rd = ex_rd;
    assign fi.ex_regwrite = ex_regwrite;
    assign ni.ex_regwrite = ex_regwrite;
    assign fi.ex_memread = ex_memread;
    assign ni.ex_memread = ex_memread;
    assign fi.mem_rd = mem_rd;       assign ni.mem_rd = mem_rd;
    assign fi.mem_regwrite = mem_regwrite;
    assign ni.mem_regwrite = mem_regwrite;
    assign fi.wb_rd = wb_rd;         assign ni.wb_rd = wb_rd;
    assign fi.wb_regwrite = wb_regwrite;
    assign ni.wb_regwrite = wb_regwrite;
    assign fi.redirect = redirect;   assign ni.redirect = redirect;
    assign fi.wb_valid = wb_valid;   assign ni.wb_valid = wb_valid;
    assign fi.wb_halt = wb_halt;     assign ni.wb_halt = wb_halt;

    assign si.id_rs = id_rs;         assign si.id_rt = id_rt;
    assign si.id_use_rs = id_use_rs; assign si.id_use_rt = id_use_rt;
    assign si.ex_rs = ex_rs;         assign si.ex_rt = ex_rt;
    assign si.ex_rd = ex_rd;         assign si.ex_regwrite = ex_regwrite;
    assign si.ex_memread = ex_memread;
    assign si.mem_rd = mem_rd;       assign si.mem_regwrite = mem_regwrite;
    assign si.wb_rd = wb_rd;         assign si.wb_regwrite = wb_regwrite;
    assign si.redirect = redirect;   assign si.wb_valid = wb_valid;
    assign si.wb_halt = wb_halt;

    hazard_ctrl_unit #(
        .REG_AW(5), .FORWARDING(1), .FLUSH_CYCLES(2), .CNT_W(32)
    ) u_f (.clk(clk), .rst(rst), .bus(fi));

    hazard_ctrl_unit #(
        .REG_AW(5), .FORWARDING(0), .FLUSH_CYCLES(2), .CNT_W(32)
    ) u_n (.clk(clk), .rst(rst), .bus(ni));

    hazard_ctrl_unit #(
        .REG_AW(5), .FORWARDING(1), .FLUSH_CYCLES(2), .CNT_W(4)
    ) u_s (.clk(clk), .rst(rst), .bus(si));

    // {pc_write, ifid_write, ifid_flush, idex_bubble, exdm_flush}
    logic [4:0] f_ctl, n_ctl;
    assign f_ctl = {fi.pc_write, fi.ifid_write, fi.ifid_flush,
                    fi.idex_bubble, fi.exdm_flush};
    assign n_ctl = {ni.pc_write, ni.ifid_write, ni.ifid_flush,
                    ni.idex_bubble, ni.exdm_flush};

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
        ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_use_rs = 0; id_use_rt = 0; ex_regwrite = 0; ex_memread = 0;
        mem_regwrite = 0; wb_regwrite = 0; redirect = 0;
        wb_valid = 0; wb_halt = 0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        ex_rs = 5'd3; mem_rd = 5'd3; mem_regwrite = 1;
        rst = 1'b1;
        @(posedge clk);
        #3;
        n_chk++;
        if (f_ctl !== 5'b00111)
            $display("FAIL rst_ctl got %b exp 00111", f_ctl);
        else n_pass++;
        n_chk++;
        if ({fi.fwd_a, fi.halted, fi.cycle_cnt} !== {2'b00, 1'b0, 32'd0})
            $display("FAIL rst_state got fwd=%b h=%b c=%0d exp 00/0/0",
                     fi.fwd_a, fi.halted, fi.cycle_cnt);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({f_ctl, fi.fwd_a} !== {5'b11000, 2'b10})
            $display("FAIL rst_release got %b/%b exp 11000/10",
                     f_ctl, fi.fwd_a);
        else n_pass++;
        next_cyc();
        n_chk++;
        if (fi.cycle_cnt !== 32'd1)
            $display("FAIL rst_first_edge got %0d exp 1", fi.cycle_cnt);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd2;
        id_use_rs = 1; id_rs = 5'd2;
        #2;
        n_chk++;
        if (f_ctl !== 5'b00010)
            $display("FAIL lu_stall got %b exp 00010", f_ctl);
        else n_pass++;
        next_cyc();
        ex_memread = 0; ex_regwrite = 0; ex_rd = '0;
        mem_rd = 5'd2; mem_regwrite = 1;
        #2;
        n_chk++;
        if (f_ctl !== 5'b11000)
            $display("FAIL lu_clear got %b exp 11000", f_ctl);
        else n_pass++;
        next_cyc();
        ex_rs = 5'd2; mem_rd = '0; mem_regwrite = 0;
        wb_rd = 5'd2; wb_regwrite = 1; id_use_rs = 0;
        #2;
        n_chk++;
        if (fi.fwd_a !== 2'b01)
            $display("FAIL lu_fwd got %b exp 01", fi.fwd_a);
        else n_pass++;
        n_chk++;
        if (fi.bubble_cnt !== 32'd1)
            $display("FAIL lu_bubbles got %0d exp 1", fi.bubble_cnt);
        else n_pass++;
        idle();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd7;
        id_use_rt = 1; id_rt = 5'd7;
        #2;
        n_chk++;
        if (f_ctl !== 5'b00010)
            $display("FAIL lu_rt got %b exp 00010", f_ctl);
        else n_pass++;
        id_use_rt = 0;
        #2;
        n_chk++;
        if (f_ctl !== 5'b11000)
            $display("FAIL lu_unused got %b exp 11000", f_ctl);
        else n_pass++;
        ex_rd = '0; id_rt = '0; id_use_rt = 1;
        #2;
        n_chk++;
        if (f_ctl !== 5'b11000)
            $display("FAIL lu_r0 got %b exp 11000", f_ctl);
        else n_pass++;
    endtask

    task automatic test_fwd_priority();
        do_reset();
        ex_rs = 5'd3; ex_rt = 5'd3;
        mem_rd = 5'd3; mem_regwrite = 1;
        wb_rd = 5'd3; wb_regwrite = 1;
        #2;
        n_chk++;
        if ({fi.fwd_a, fi.fwd_b} !== 4'b1010)
            $display("FAIL fwd_prio got %b exp 1010", {fi.fwd_a, fi.fwd_b});
        else n_pass++;
        n_chk++;
        if ({ni.fwd_a, ni.fwd_b} !== 4'b0000)
            $display("FAIL nofwd_zero got %b exp 0000", {ni.fwd_a, ni.fwd_b});
        else n_pass++;
        mem_regwrite = 0; ex_rt = 5'd5;
        #2;
        n_chk++;
        if ({fi.fwd_a, fi.fwd_b} !== 4'b0100)
            $display("FAIL fwd_wb got %b exp 0100", {fi.fwd_a, fi.fwd_b});
        else n_pass++;
        ex_rs = '0; ex_rt = '0; mem_rd = '0; mem_regwrite = 1; wb_rd = '0;
        #2;
        n_chk++;
        if ({fi.fwd_a, fi.fwd_b, f_ctl} !== {4'b0000, 5'b11000})
            $display("FAIL fwd_r0 got %b/%b exp 0000/11000",
                     {fi.fwd_a, fi.fwd_b}, f_ctl);
        else n_pass++;
    endtask

    task automatic test_stall_only();
        do_reset();
        ex_rd = 5'd4; ex_regwrite = 1; id_use_rs = 1; id_rs = 5'd4;
        #2;
        n_chk++;
        if (n_ctl !== 5'b00010)
            $display("FAIL so_ex got %b exp 00010", n_ctl);
        else n_pass++;
        n_chk++;
        if (f_ctl !== 5'b11000)
            $display("FAIL so_fwd_nostall got %b exp 11000", f_ctl);
        else n_pass++;
        next_cyc();
        ex_regwrite = 0; ex_rd = '0; ex_rs = 5'd4;
        mem_rd = 5'd4; mem_regwrite = 1;
        #2;
        n_chk++;
        if ({n_ctl, ni.fwd_a} !== {5'b00010, 2'b00})
            $display("FAIL so_mem got %b/%b exp 00010/00", n_ctl, ni.fwd_a);
        else n_pass++;
        next_cyc();
        mem_regwrite = 0; mem_rd = '0; wb_rd = 5'd4; wb_regwrite = 1;
        #2;
        n_chk++;
        if ({n_ctl, ni.fwd_a} !== {5'b11000, 2'b00})
            $display("FAIL so_wb got %b/%b exp 11000/00", n_ctl, ni.fwd_a);
        else n_pass++;
        n_chk++;
        if (ni.bubble_cnt !== 32'd2)
            $display("FAIL so_bubbles got %0d exp 2", ni.bubble_cnt);
        else n_pass++;
    endtask

    task automatic test_redirect();
        do_reset();
        redirect = 1;
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd6;
        id_use_rs = 1; id_rs = 5'd6;
        #2;
        n_chk++;
        if (f_ctl !== 5'b11111)
            $display("FAIL rd_first got %b exp 11111", f_ctl);
        else n_pass++;
        next_cyc();
        redirect = 0;
        #2;
        n_chk++;
        if (f_ctl !== 5'b11100)
            $display("FAIL rd_flush got %b exp 11100", f_ctl);
        else n_pass++;
        next_cyc();
        #2;
        n_chk++;
        if (f_ctl !== 5'b00010)
            $display("FAIL rd_run_stall got %b exp 00010", f_ctl);
        else n_pass++;
        next_cyc();
        idle();
        redirect = 1;
        next_cyc();
        #2;
        n_chk++;
        if (f_ctl !== 5'b11111)
            $display("FAIL rd_again got %b exp 11111", f_ctl);
        else n_pass++;
        next_cyc();
        redirect = 0;
        #2;
        n_chk++;
        if (f_ctl !== 5'b11100)
            $display("FAIL rd_extend got %b exp 11100", f_ctl);
        else n_pass++;
        next_cyc();
        #2;
        n_chk++;
        if (f_ctl !== 5'b11000)
            $display("FAIL rd_back_run got %b exp 11000", f_ctl);
        else n_pass++;
        n_chk++;
        if ({fi.bubble_cnt, fi.cycle_cnt} !== {32'd6, 32'd6})
            $display("FAIL rd_counts got b=%0d c=%0d exp 6/6",
                     fi.bubble_cnt, fi.cycle_cnt);
        else n_pass++;
        redirect = 1;
        next_cyc();
        redirect = 0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        n_chk++;
        if (f_ctl !== 5'b11000)
            $display("FAIL rd_rst_abort got %b exp 11000", f_ctl);
        else n_pass++;
    endtask

    task automatic test_halt();
        do_reset();
        wb_valid = 1;
        next_cyc();
        wb_valid = 0;
        next_cyc();
        wb_valid = 1;
        next_cyc();
        wb_halt = 1;
        #2;
        n_chk++;
        if ({fi.cycle_cnt, fi.retired_cnt, fi.halted} !==
            {32'd3, 32'd2, 1'b0})
            $display("FAIL halt_pre got c=%0d r=%0d h=%b exp 3/2/0",
                     fi.cycle_cnt, fi.retired_cnt, fi.halted);
        else n_pass++;
        next_cyc();
        wb_halt = 0; redirect = 1;
        #2;
        n_chk++;
        if ({fi.halted, f_ctl} !== {1'b1, 5'b00010})
            $display("FAIL halt_ctl got h=%b ctl=%b exp 1/00010",
                     fi.halted, f_ctl);
        else n_pass++;
        repeat (3) next_cyc();
        n_chk++;
        if ({fi.cycle_cnt, fi.retired_cnt, fi.bubble_cnt, fi.halted} !==
            {32'd4, 32'd3, 32'd0, 1'b1})
            $display("FAIL halt_frozen got c=%0d r=%0d b=%0d h=%b exp 4/3/0/1",
                     fi.cycle_cnt, fi.retired_cnt, fi.bubble_cnt, fi.halted);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({fi.halted, fi.cycle_cnt, fi.retired_cnt} !==
            {1'b0, 32'd0, 32'd0})
            $display("FAIL halt_rst got h=%b c=%0d r=%0d exp 0/0/0",
                     fi.halted, fi.cycle_cnt, fi.retired_cnt);
        else n_pass++;
        rst = 1'b0;
        idle();
        next_cyc();
        n_chk++;
        if ({fi.halted, fi.cycle_cnt} !== {1'b0, 32'd1})
            $display("FAIL halt_resume got h=%b c=%0d exp 0/1",
                     fi.halted, fi.cycle_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (14) next_cyc();
        n_chk++;
        if (si.cycle_cnt !== 4'd14)
            $display("FAIL sat_below got %0d exp 14", si.cycle_cnt);
        else n_pass++;
        repeat (6) next_cyc();
        n_chk++;
        if ({si.cycle_cnt, fi.cycle_cnt} !== {4'd15, 32'd20})
            $display("FAIL sat_hold got %0d/%0d exp 15/20",
                     si.cycle_cnt, fi.cycle_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_stall_only();
        test_redirect();
        test_halt();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Synthesizable, parametrised pipeline hazard controller for the five-stage IF/ID/EX/DM/WB core. It sits beside the stage registers and drives:
- PC and IF/ID hold for data hazards;
- ID/EX bubbles and IF/ID flushes for data hazards and for taken branch/jump redirects;
- EX-stage operand forwarding selects;
- a halt state;
- cycle, bubble and retired-instruction counters for CPI.

In forwarding mode it replaces the full RAW stall with a single-cycle load-use stall.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- FORWARDING, 1, 1 = forwarding plus load-use stall; 0 = stall-only (no forwarding).
- FLUSH_CYCLES, 2, cycles IF/ID is held flushed after a redirect (≥1).
- CNT_W, 32, counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt.
- ex_rs, ex_rt  in  REG_AW  source registers of the instruction in EX.
- ex_rd  in  REG_AW  destination register of EX.
- ex_regwrite, ex_memread  in  1  EX controls.
- mem_rd  in  REG_AW  destination register of DM.
- mem_regwrite  in  1  DM control.
- wb_rd  in  REG_AW  destination register of WB.
- wb_regwrite  in  1  WB control.
- redirect  in  1  taken branch or jump resolved in DM this cycle.
- wb_valid  in  1  non-bubble instruction retiring.
- wb_halt  in  1  end instruction in WB.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads zero controls.
- exdm_flush  out  1  EX/DM loads zero controls.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 EX/DM ALU result, 01 DM/WB writeback data.
- halted  out  1  core stopped.
- cycle_cnt, bubble_cnt, retired_cnt  out  CNT_W  performance counters.

## Operation
- Register 0 never creates a hazard or a forward. A match also requires the corresponding use/regwrite bit.
- Data stall:
  - FORWARDING=1: stall when ex_memread and ex_rd matches a used id_rs or id_rt.
  - FORWARDING=0: stall on any match with ex_rd (ex_regwrite) or mem_rd (mem_regwrite).
  - The WB write and the ID regfile read in the same cycle need no stall; the regfile writes first.
- Stall response: pc_write=0, ifid_write=0, idex_bubble=1. Re-evaluated every cycle until clear.
- Forwarding:
  - fwd_a=10 if mem_regwrite and mem_rd==ex_rs; else 01 if wb_regwrite and wb_rd==ex_rs; else 00. fwd_b uses ex_rt the same way.
  - EX/DM has priority over DM/WB.
  - With FORWARDING=0, fwd_a and fwd_b are held at 00.
- FSM states: RUN, FLUSH, HALT.
  - RUN, redirect=1: ifid_flush=1, idex_bubble=1, exdm_flush=1 combinationally; pc_write=1 so the PC loads the target. Load flush_left=FLUSH_CYCLES-1; go to FLUSH if flush_left>0, else stay in RUN.
  - FLUSH: ifid_flush=1, data stalls suppressed, flush_left decrements; go to RUN when it reaches 0.
  - FLUSH, redirect=1: reload flush_left and assert the full flush again.
  - Any state, wb_halt=1: go to HALT.
  - HALT: pc_write=ifid_write=0, idex_bubble=1, halted=1. Only rst exits HALT.
- Priority: halt > redirect > data stall. A stall in the same cycle as a redirect is dropped.
- Counters saturate at all-ones and freeze in HALT.
  - cycle_cnt +1 every cycle.
  - bubble_cnt +1 each cycle with idex_bubble=1 or ifid_flush=1 (counted once per cycle).
  - retired_cnt +1 when wb_valid.

## Timing
- Hazard, forward and flush outputs are combinational from the inputs and the current state: zero-cycle response.
- FSM state, flush_left and counters update on the rising clk edge.
- While rst=1, regardless of clk:
  - state=RUN, flush_left=0, counters=0, halted=0;
  - pc_write=ifid_write=0, ifid_flush=idex_bubble=exdm_flush=1, fwd=00.
- Reset mid-flush or in HALT aborts to RUN immediately.
- First edge after rst falls: normal operation; cycle_cnt reads 1 after that edge.
- A load-use stall lasts exactly 1 cycle when FORWARDING=1. A stall-only RAW hazard lasts up to 2 cycles.

## Test plan
- FORWARDING=1; EX lw r2 (ex_memread=1, ex_rd=2) with ID reading id_rs=2 -> 1 cycle pc_write=0, idex_bubble=1. Next cycle clear; fwd_a=01 when the add reaches EX. bubble_cnt=1.
- FORWARDING=1; mem_rd=3 regwrite and wb_rd=3 regwrite, ex_rs=3 -> fwd_a=10 (EX/DM priority). Set ex_rs=0 with mem_rd=0 -> fwd_a=00, no stall.
- FORWARDING=0; ex_rd=4 regwrite, ID reads r4 -> stalls 2 cycles as the write moves EX→DM→WB; then proceeds. fwd stays 00 throughout.
- FLUSH_CYCLES=2; redirect pulse at cycle 10 -> cycle 10 all three flushes, pc_write=1; cycle 11 ifid_flush=1 with a simultaneous load-use hazard ignored; cycle 12 RUN. Second redirect at cycle 11 -> flush extends to cycle 13.
- wb_halt at cycle 20 -> halted=1 from cycle 21; counters frozen at their cycle-20 values. rst pulse -> all counters 0, halted=0.
- Saturation: CNT_W=4, 20 free-running cycles -> cycle_cnt holds at 15.
